// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: ALU opcodes, MIPS funct codes
// and the response FIFO entry layout.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 4;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_NOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_ADD  = 4'd6,
        ALU_SUB  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLT  = 4'd9
    } aluop_t;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] data;
        logic                  neg;
        logic                  zero;
        logic                  ovf;
        logic                  err;
        logic [ALU_TAG_W-1:0]  tag;
    } resp_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS funct -> ALU opcode decoder.
// ALU_OVF_TRAP_EN marks signed ADD/SUB as overflow-trap capable.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] i_funct,
    output aluop_t     o_aluop,
    output logic       o_legal,
    output logic       o_trap_cap
);

`ifdef ALU_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    always_comb begin
        o_aluop    = ALU_AND;
        o_legal    = 1'b1;
        o_trap_cap = 1'b0;
        case (i_funct)
            FUNCT_AND:  o_aluop = ALU_AND;
            FUNCT_OR:   o_aluop = ALU_OR;
            FUNCT_XOR:  o_aluop = ALU_XOR;
            FUNCT_NOR:  o_aluop = ALU_NOR;
            FUNCT_SLL:  o_aluop = ALU_SLL;
            FUNCT_SRL:  o_aluop = ALU_SRL;
            FUNCT_ADD: begin
                o_aluop    = ALU_ADD;
                o_trap_cap = TRAP_EN;
            end
            FUNCT_ADDU: o_aluop = ALU_ADD;
            FUNCT_SUB: begin
                o_aluop    = ALU_SUB;
                o_trap_cap = TRAP_EN;
            end
            FUNCT_SUBU: o_aluop = ALU_SUB;
            FUNCT_SLTU: o_aluop = ALU_SLTU;
            FUNCT_SLT:  o_aluop = ALU_SLT;
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: IDLE/EXEC sequencer driving an external ALU and an
// in-order FWFT response FIFO. Overflow trapping enabled by ALU_OVF_TRAP_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int TAG_W      = ALU_TAG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_funct,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_portA,
    output logic [DATA_W-1:0] alu_portB,
    output logic [3:0]        alu_aluop,
    input  logic [DATA_W-1:0] alu_outPort,
    input  logic              alu_negF,
    input  logic              alu_zerF,
    input  logic              alu_oveF,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_neg,
    output logic              resp_zero,
    output logic              resp_ovf,
    output logic              resp_err,
    output logic [TAG_W-1:0]  resp_tag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t            r_state;
    logic              r_ready;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [TAG_W-1:0]  r_tag;
    aluop_t            r_aluop;
    logic              r_illegal;
    logic              r_trap;

    resp_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_used;
    logic [CNT_W-1:0]  r_rsv;

    aluop_t            w_aluop;
    logic              w_legal;
    logic              w_trap_cap;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_err;
    logic [CNT_W-1:0]  w_rsv_next;
    logic [CNT_W-1:0]  w_used_next;
    resp_t             w_entry;

    alu_funct_decode u_dec (
        .i_funct    (cmd_funct),
        .o_aluop    (w_aluop),
        .o_legal    (w_legal),
        .o_trap_cap (w_trap_cap)
    );

    assign w_accept = cmd_valid && r_ready;
    assign w_push   = (r_state == S_EXEC);
    assign w_pop    = resp_valid && resp_ready;

    // r_rsv counts occupied plus in-flight slots, so a push never sees full
    assign w_rsv_next  = r_rsv + CNT_W'(w_accept) - CNT_W'(w_pop);
    assign w_used_next = r_used + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_err = r_illegal || (r_trap && alu_oveF);

    always_comb begin
        w_entry      = '0;
        w_entry.data = w_err ? '0 : alu_outPort;
        w_entry.neg  = r_illegal ? 1'b0 : alu_negF;
        w_entry.zero = r_illegal ? 1'b0 : alu_zerF;
        w_entry.ovf  = r_illegal ? 1'b0 : alu_oveF;
        w_entry.err  = w_err;
        w_entry.tag  = r_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_aluop   <= ALU_AND;
            r_illegal <= 1'b0;
            r_trap    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_used    <= '0;
            r_rsv     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rsv  <= w_rsv_next;
            r_used <= w_used_next;
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_EXEC;
                        r_ready   <= 1'b0;
                        r_a       <= cmd_a;
                        r_b       <= cmd_b;
                        r_tag     <= cmd_tag;
                        r_aluop   <= w_legal ? w_aluop : ALU_AND;
                        r_illegal <= !w_legal;
                        r_trap    <= w_trap_cap;
                    end else begin
                        r_ready <= (w_rsv_next < DEPTH_C);
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_ready <= (w_rsv_next < DEPTH_C);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign alu_portA  = r_a;
    assign alu_portB  = r_b;
    assign alu_aluop  = r_aluop;

    assign resp_valid = (r_used != '0);
    assign resp_data  = r_mem[r_rptr].data;
    assign resp_neg   = r_mem[r_rptr].neg;
    assign resp_zero  = r_mem[r_rptr].zero;
    assign resp_ovf   = r_mem[r_rptr].ovf;
    assign resp_err   = r_mem[r_rptr].err;
    assign resp_tag   = r_mem[r_rptr].tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a
// scoreboard queue of expected responses.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        neg;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_funct = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [31:0] alu_portA;
    logic [31:0] alu_portB;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_outPort;
    logic        alu_negF;
    logic        alu_zerF;
    logic        alu_oveF;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_neg;
    logic        resp_zero;
    logic        resp_ovf;
    logic        resp_err;
    logic [3:0]  resp_tag;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_portA(alu_portA), .alu_portB(alu_portB), .alu_aluop(alu_aluop),
        .alu_outPort(alu_outPort), .alu_negF(alu_negF),
        .alu_zerF(alu_zerF), .alu_oveF(alu_oveF),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_neg(resp_neg), .resp_zero(resp_zero),
        .resp_ovf(resp_ovf), .resp_err(resp_err), .resp_tag(resp_tag)
    );

    // Behavioural combinational ALU on the far side of the interface
    logic [31:0] m_out;
    logic        m_ovf;
    always_comb begin
        m_out = '0;
        m_ovf = 1'b0;
        case (alu_aluop)
            4'd0: m_out = alu_portA & alu_portB;
            4'd1: m_out = alu_portA | alu_portB;
            4'd2: m_out = alu_portA ^ alu_portB;
            4'd3: m_out = ~(alu_portA | alu_portB);
            4'd4: m_out = alu_portB << alu_portA[4:0];
            4'd5: m_out = alu_portB >> alu_portA[4:0];
            4'd6: begin
                m_out = alu_portA + alu_portB;
                m_ovf = (alu_portA[31] == alu_portB[31]) && (m_out[31] != alu_portA[31]);
            end
            4'd7: begin
                m_out = alu_portA - alu_portB;
                m_ovf = (alu_portA[31] != alu_portB[31]) && (m_out[31] != alu_portA[31]);
            end
            4'd8: m_out = {31'd0, alu_portA < alu_portB};
            4'd9: m_out = {31'd0, $signed(alu_portA) < $signed(alu_portB)};
            default: m_out = '0;
        endcase
    end
    assign alu_outPort = m_out;
    assign alu_negF    = m_out[31];
    assign alu_zerF    = (m_out == 32'd0);
    assign alu_oveF    = m_ovf;

    task automatic send(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t,
                        output int acc_cyc);
        bit done = 0;
        cmd_funct = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = t;
        cmd_valid = 1'b1;
        acc_cyc   = -1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (cmd_ready) done = 1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (done) begin
            acc_cyc = cyc;
        end else begin
            n_total++;
            $display("FAIL send_timeout tag=%0d cmd_ready never high", t);
        end
    endtask

    task automatic get_resp(output exp_t obs);
        bit got = 0;
        obs = 'x;
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (resp_valid) begin
                got = 1;
                obs = {resp_data, resp_neg, resp_zero, resp_ovf, resp_err, resp_tag};
            end
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL resp_timeout no resp_valid within 40 cycles");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b exp=0", resp_valid);
        else n_pass++;
        n_total++;
        if ({alu_portA, alu_portB, alu_aluop} !== 68'd0)
            $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_portA, alu_portB, alu_aluop);
        else n_pass++;
        n_total++;
        if ({resp_data, resp_err, resp_tag} !== 37'd0)
            $display("FAIL rst_resp got=%h/%b/%h exp=0", resp_data, resp_err, resp_tag);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_and;
        int   ac;
        exp_t obs, e;
        sb.push_back({32'h0000002C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1});
        send(6'h24, 32'hFFFFFFFC, 32'd45, 4'd1, ac);
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL and_valid_early got=%b exp=0", resp_valid);
        else n_pass++;
        n_total++;
        if ({alu_portA, alu_portB, alu_aluop} !== {32'hFFFFFFFC, 32'd45, 4'd0})
            $display("FAIL and_alu_drive got=%h/%h/%h exp=fffffffc/2d/0",
                     alu_portA, alu_portB, alu_aluop);
        else n_pass++;
        // the end-of-EXEC edge pushes the entry
        @(posedge clk);
        #1;
        n_total++;
        if (resp_valid !== 1'b1) $display("FAIL and_valid_latency got=%b exp=1", resp_valid);
        else n_pass++;
        n_total++;
        if (alu_portA !== 32'hFFFFFFFC) $display("FAIL and_alu_hold got=%h exp=fffffffc", alu_portA);
        else n_pass++;
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL and_resp got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_sub_add;
        int   ac;
        exp_t obs, e;
        sb.push_back({32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2});
        send(6'h22, 32'd50, 32'd50, 4'd2, ac);
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL sub_zero got=%h exp=%h", obs, e);
        else n_pass++;
`ifdef ALU_OVF_TRAP_EN
        sb.push_back({32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3});
`else
        sb.push_back({32'hFA56EA00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3});
`endif
        send(6'h20, 32'd2100000000, 32'd2100000000, 4'd3, ac);
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL add_ovf got=%h exp=%h", obs, e);
        else n_pass++;
        sb.push_back({32'hFA56EA00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4});
        send(6'h21, 32'd2100000000, 32'd2100000000, 4'd4, ac);
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL addu_notrap got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_slt;
        int   ac;
        exp_t obs, e;
        sb.push_back({32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5});
        sb.push_back({32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6});
        send(6'h2A, -32'sd10, 32'd67, 4'd5, ac);
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL slt got=%h exp=%h", obs, e);
        else n_pass++;
        send(6'h2B, -32'sd10, 32'd67, 4'd6, ac);
        n_total++;
        if (alu_aluop !== 4'd8) $display("FAIL sltu_aluop got=%0d exp=8", alu_aluop);
        else n_pass++;
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL sltu got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_illegal;
        int   ac;
        exp_t obs, e;
        sb.push_back({32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7});
        send(6'h3F, 32'd5, 32'd7, 4'd7, ac);
        n_total++;
        if (alu_aluop !== 4'd0) $display("FAIL illegal_aluop got=%0d exp=0", alu_aluop);
        else n_pass++;
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL illegal_resp got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_fifo_full;
        int   ac;
        bit   back;
        exp_t obs, e;
        resp_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            sb.push_back({32'(t), 1'b0, 1'b0, 1'b0, 1'b0, 4'(t)});
            send(6'h24, 32'(t), 32'hFFFFFFFF, 4'(t), ac);
        end
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cmd_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", cmd_ready);
        else n_pass++;
        get_resp(obs);
        e = sb.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL full_pop1 got=%h exp=%h", obs, e);
        else n_pass++;
        back = 0;
        for (int i = 0; i < 4 && !back; i++) begin
            if (cmd_ready) back = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_total++;
        if (!back) $display("FAIL full_ready_return got=%b exp=1", cmd_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            get_resp(obs);
            e = sb.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL drain_order idx=%0d got=%h exp=%h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int acc[3];
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    sb.push_back({32'(i + 3), 1'b0, 1'b0, 1'b0, 1'b0, 4'(8 + i)});
                    send(6'h20, 32'(i + 1), 32'd2, 4'(8 + i), acc[i]);
                end
            end
            begin
                exp_t obs, e;
                for (int i = 0; i < 3; i++) begin
                    get_resp(obs);
                    e = sb.pop_front();
                    n_total++;
                    if (obs !== e) $display("FAIL b2b_resp idx=%0d got=%h exp=%h", i, obs, e);
                    else n_pass++;
                end
            end
        join
        n_total++;
        if ((acc[1] - acc[0]) !== 2 || (acc[2] - acc[1]) !== 2)
            $display("FAIL b2b_rate gaps=%0d,%0d exp=2,2", acc[1] - acc[0], acc[2] - acc[1]);
        else n_pass++;
    endtask

    task automatic test_reset_exec;
        int ac;
        send(6'h22, 32'd9, 32'd3, 4'd12, ac);
        // state is EXEC now; abort it asynchronously
        rst = 1'b1;
        #2;
        n_total++;
        if ({resp_valid, cmd_ready, alu_aluop} !== 6'd0)
            $display("FAIL rstx_during got=%b/%b/%0d exp=0/0/0", resp_valid, cmd_ready, alu_aluop);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL rstx_ready got=%b exp=1", cmd_ready);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rstx_no_resp got=%b exp=0", resp_valid);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_and();
        test_sub_add();
        test_slt();
        test_illegal();
        test_fifo_full();
        test_back_to_back();
        test_reset_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
